// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: widths, branch funct3 codes,
// writeback select encodings and the EX/MEM squash FSM states.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM boundary stage.
// slave: the stage itself; master: whatever drives EX and consumes MEM.
interface ex_mem_stage_if;
  import rv_pkg::*;

  logic            ValidE;
  logic            StallM;
  logic            FlushM;
  logic [XLEN-1:0] ALUResultE;
  logic            ZeroE;
  logic            NegativeE;
  logic            OverFlowE;
  logic            CarryE;
  logic [XLEN-1:0] WriteDataE;
  logic [RA_W-1:0] RdE;
  logic [XLEN-1:0] PCPlus4E;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            BranchE;
  logic            JumpE;
  logic            JalrE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      Funct3E;

  logic            ValidM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic [RA_W-1:0] RdM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic            RedirectM;
  logic [XLEN-1:0] RedirectPCM;

  modport slave (
    input  ValidE, StallM, FlushM, ALUResultE, ZeroE, NegativeE, OverFlowE,
           CarryE, WriteDataE, RdE, PCPlus4E, PCTargetE, RegWriteE,
           MemWriteE, BranchE, JumpE, JalrE, ResultSrcE, Funct3E,
    output ValidM, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM,
           MemWriteM, ResultSrcM, RedirectM, RedirectPCM
  );

  modport master (
    output ValidE, StallM, FlushM, ALUResultE, ZeroE, NegativeE, OverFlowE,
           CarryE, WriteDataE, RdE, PCPlus4E, PCTargetE, RegWriteE,
           MemWriteE, BranchE, JumpE, JalrE, ResultSrcE, Funct3E,
    input  ValidM, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM,
           MemWriteM, ResultSrcM, RedirectM, RedirectPCM
  );

endinterface

// File: rtl/branch_cond.sv
// Branch condition from funct3 and the flags of an A-B subtraction.
// Carry is the no-borrow carry-out, so A<B unsigned is ~carry.
module branch_cond
  import rv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       carry,
  output logic       taken
);

  // Decode the comparison selected by funct3; reserved codes never branch.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = negative ^ overflow;
      F3_BGE:  taken = ~(negative ^ overflow);
      F3_BLTU: taken = ~carry;
      F3_BGEU: taken = carry;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, a one-cycle PC
// redirect pulse and a squash of the single wrong-path instruction that
// reaches EX behind a taken control transfer.
module ex_mem_stage
  import rv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);

  logic            cond_taken;
  logic            live;
  logic            taken_e;
  logic [XLEN-1:0] target_e;
  state_t          state;

  branch_cond u_branch_cond (
    .funct3   (bus.Funct3E),
    .zero     (bus.ZeroE),
    .negative (bus.NegativeE),
    .overflow (bus.OverFlowE),
    .carry    (bus.CarryE),
    .taken    (cond_taken)
  );

  // EX-side resolution: the slot after a taken transfer is never live.
  always_comb begin
    live     = bus.ValidE & (state == RUN);
    taken_e  = live & (bus.JumpE | bus.JalrE | (bus.BranchE & cond_taken));
    target_e = bus.JalrE ? {bus.ALUResultE[XLEN-1:1], 1'b0} : bus.PCTargetE;
  end

  // EX/MEM register, redirect pulse and squash FSM; rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      bus.ValidM      <= 1'b0;
      bus.ALUResultM  <= '0;
      bus.WriteDataM  <= '0;
      bus.PCPlus4M    <= '0;
      bus.RdM         <= '0;
      bus.RegWriteM   <= 1'b0;
      bus.MemWriteM   <= 1'b0;
      bus.ResultSrcM  <= '0;
      bus.RedirectM   <= 1'b0;
      bus.RedirectPCM <= '0;
    end else if (bus.FlushM) begin
      // Bubble in M; any transfer resolved this cycle is dropped.
      state         <= RUN;
      bus.ValidM    <= 1'b0;
      bus.RegWriteM <= 1'b0;
      bus.MemWriteM <= 1'b0;
      bus.RedirectM <= 1'b0;
    end else if (bus.StallM) begin
      // Hold M and state, but the redirect is still a single-cycle pulse.
      bus.RedirectM <= 1'b0;
    end else begin
      bus.ValidM     <= live;
      bus.ALUResultM <= bus.ALUResultE;
      bus.WriteDataM <= bus.WriteDataE;
      bus.PCPlus4M   <= bus.PCPlus4E;
      bus.RdM        <= bus.RdE;
      bus.RegWriteM  <= bus.RegWriteE & live;
      bus.MemWriteM  <= bus.MemWriteE & live;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.RedirectM  <= taken_e;
      if (taken_e) begin
        bus.RedirectPCM <= target_e;
      end
      case (state)
        RUN:     state <= taken_e ? SQUASH : RUN;
        SQUASH:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each step drives one EX slot, pushes
// the hand-computed M-stage expectation, clocks once and checks it.
module tb_ex_mem_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regw;
    logic        memw;
    logic        redir;
    logic [31:0] rpc;
    bit          chk_data;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic v, input logic rw, input logic mw, input logic rd_,
                      input logic [31:0] rpc, input bit cd, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.regw = rw; e.memw = mw; e.redir = rd_; e.rpc = rpc;
    e.chk_data = cd; e.alu = alu; e.pc4 = pc4; e.rd = rd;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic rw, input logic mw, input logic br,
                       input logic jmp, input logic jalr, input logic [2:0] f3,
                       input logic z, input logic n, input logic ov, input logic c,
                       input logic [31:0] alu, input logic [31:0] pct,
                       input logic [31:0] pc4, input logic [4:0] rd);
    bus.ValidE = v; bus.RegWriteE = rw; bus.MemWriteE = mw; bus.BranchE = br;
    bus.JumpE = jmp; bus.JalrE = jalr; bus.Funct3E = f3;
    bus.ZeroE = z; bus.NegativeE = n; bus.OverFlowE = ov; bus.CarryE = c;
    bus.ALUResultE = alu; bus.PCTargetE = pct; bus.PCPlus4E = pc4; bus.RdE = rd;
    bus.WriteDataE = 32'hDEAD0000 | {27'd0, rd};
    bus.ResultSrcE = jalr | jmp ? RS_PC4 : RS_ALU;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  // Clock one edge, then pop the oldest expectation and compare it.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed %0d expected 1", tag, q.size());
    end else begin
      e = q.pop_front();
      chk({tag, ".ValidM"},      {31'd0, bus.ValidM},    {31'd0, e.valid});
      chk({tag, ".RegWriteM"},   {31'd0, bus.RegWriteM}, {31'd0, e.regw});
      chk({tag, ".MemWriteM"},   {31'd0, bus.MemWriteM}, {31'd0, e.memw});
      chk({tag, ".RedirectM"},   {31'd0, bus.RedirectM}, {31'd0, e.redir});
      chk({tag, ".RedirectPCM"}, bus.RedirectPCM,        e.rpc);
      if (e.chk_data) begin
        chk({tag, ".ALUResultM"}, bus.ALUResultM,       e.alu);
        chk({tag, ".PCPlus4M"},   bus.PCPlus4M,         e.pc4);
        chk({tag, ".RdM"},        {27'd0, bus.RdM},     {27'd0, e.rd});
      end
    end
  endtask

  initial begin
    bus.StallM = 1'b0;
    bus.FlushM = 1'b0;
    drive(1, 1, 1, 0, 0, 0, 3'b000, 1, 1, 1, 1, 32'h1234, 32'h80, 32'h84, 5'd9);
    push(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 5'd0);
    tick("reset");
    rst = 1'b0;

    // BEQ 5==5 taken, then the wrong-path write is squashed.
    drive(1, 0, 0, 1, 0, 0, F3_BEQ, 1, 0, 0, 1, 32'h0, 32'h100, 32'h104, 5'd0);
    push(1, 0, 0, 1, 32'h100, 1, 32'h0, 32'h104, 5'd0);
    tick("beq_taken");
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h55, 32'h0, 32'h108, 5'd5);
    push(0, 0, 0, 0, 32'h100, 0, 32'h0, 32'h0, 5'd0);
    tick("beq_squash");

    // 0x7FFFFFFF - 0x80000000: N=1, V=1 -> BLT false, BGE true.
    drive(1, 0, 0, 1, 0, 0, F3_BLT, 0, 1, 1, 0, 32'hFFFFFFFF, 32'h200, 32'h204, 5'd0);
    push(1, 0, 0, 0, 32'h100, 1, 32'hFFFFFFFF, 32'h204, 5'd0);
    tick("blt_not_taken");
    drive(1, 0, 0, 1, 0, 0, F3_BGE, 0, 1, 1, 0, 32'hFFFFFFFF, 32'h200, 32'h208, 5'd0);
    push(1, 0, 0, 1, 32'h200, 1, 32'hFFFFFFFF, 32'h208, 5'd0);
    tick("bge_taken");
    drive(1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h40, 32'h0, 32'h20C, 5'd0);
    push(0, 0, 0, 0, 32'h200, 0, 32'h0, 32'h0, 5'd0);
    tick("bge_squash_store");

    // 1 - 0xFFFFFFFF borrows: C=0 -> BLTU true, BGEU false.
    drive(1, 0, 0, 1, 0, 0, F3_BLTU, 0, 0, 0, 0, 32'h2, 32'h300, 32'h304, 5'd0);
    push(1, 0, 0, 1, 32'h300, 1, 32'h2, 32'h304, 5'd0);
    tick("bltu_taken");
    idle();
    push(0, 0, 0, 0, 32'h300, 0, 32'h0, 32'h0, 5'd0);
    tick("bltu_squash");
    drive(1, 0, 0, 1, 0, 0, F3_BGEU, 0, 0, 0, 0, 32'h2, 32'h380, 32'h384, 5'd0);
    push(1, 0, 0, 0, 32'h300, 1, 32'h2, 32'h384, 5'd0);
    tick("bgeu_not_taken");

    // Reserved funct3 never branches even with Z=1.
    drive(1, 0, 0, 1, 0, 0, 3'b010, 1, 0, 0, 1, 32'h0, 32'h390, 32'h394, 5'd0);
    push(1, 0, 0, 0, 32'h300, 1, 32'h0, 32'h394, 5'd0);
    tick("f3_010_not_taken");

    // JALR clears bit 0 of the target and links.
    drive(1, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 32'h2003, 32'h999, 32'h1008, 5'd1);
    push(1, 1, 0, 1, 32'h2002, 1, 32'h2003, 32'h1008, 5'd1);
    tick("jalr");
    idle();
    push(0, 0, 0, 0, 32'h2002, 0, 32'h0, 32'h0, 5'd0);
    tick("jalr_squash");

    // Taken BEQ then two stalled cycles: pulse is single, M held, squash pending.
    drive(1, 0, 0, 1, 0, 0, F3_BEQ, 1, 0, 0, 1, 32'h11, 32'h400, 32'h404, 5'd2);
    push(1, 0, 0, 1, 32'h400, 1, 32'h11, 32'h404, 5'd2);
    tick("stall_beq");
    bus.StallM = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h99, 32'h0, 32'h408, 5'd6);
    push(1, 0, 0, 0, 32'h400, 1, 32'h11, 32'h404, 5'd2);
    tick("stall_hold1");
    push(1, 0, 0, 0, 32'h400, 1, 32'h11, 32'h404, 5'd2);
    tick("stall_hold2");
    bus.StallM = 1'b0;
    push(0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h0, 5'd0);
    tick("stall_bubble");
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h77, 32'h0, 32'h40C, 5'd7);
    push(1, 1, 0, 0, 32'h400, 1, 32'h77, 32'h40C, 5'd7);
    tick("stall_resume");

    // Flush with a taken JAL in EX: no redirect, bubble, next slot live.
    bus.FlushM = 1'b1;
    drive(1, 1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h500, 32'h504, 5'd1);
    push(0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h0, 5'd0);
    tick("flush_jal");
    bus.FlushM = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h88, 32'h0, 32'h508, 5'd8);
    push(1, 1, 0, 0, 32'h400, 1, 32'h88, 32'h508, 5'd8);
    tick("flush_next_live");

    // Flush beats stall and cancels a pending squash.
    drive(1, 0, 0, 1, 0, 0, F3_BNE, 0, 0, 0, 1, 32'h1, 32'h600, 32'h604, 5'd0);
    push(1, 0, 0, 1, 32'h600, 1, 32'h1, 32'h604, 5'd0);
    tick("bne_taken");
    bus.FlushM = 1'b1;
    bus.StallM = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h33, 32'h0, 32'h608, 5'd4);
    push(0, 0, 0, 0, 32'h600, 0, 32'h0, 32'h0, 5'd0);
    tick("flush_and_stall");
    bus.FlushM = 1'b0;
    bus.StallM = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'hAA, 32'h0, 32'h60C, 5'd10);
    push(1, 1, 0, 0, 32'h600, 1, 32'hAA, 32'h60C, 5'd10);
    tick("flush_cancels_squash");

    // Reset while squashing and redirecting.
    drive(1, 1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h0, 32'h700, 32'h704, 5'd1);
    push(1, 1, 0, 1, 32'h700, 1, 32'h0, 32'h704, 5'd1);
    tick("jal_taken");
    rst = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h44, 32'h0, 32'h708, 5'd3);
    push(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 5'd0);
    tick("reset_in_squash");
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'hBB, 32'h0, 32'h70C, 5'd3);
    push(1, 1, 0, 0, 32'h0, 1, 32'hBB, 32'h70C, 5'd3);
    tick("after_reset_live");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
